// File: rtl/tetris_score_pkg.sv
// Shared constants for the Tetris score path: point table, saturation value,
// digit count and the accumulator FSM encoding.
package tetris_score_pkg;

   localparam int SCORE_DIGITS = 4;

   localparam logic [15:0] PTS_1L    = 16'h0040;
   localparam logic [15:0] PTS_2L    = 16'h0100;
   localparam logic [15:0] PTS_3L    = 16'h0300;
   localparam logic [15:0] PTS_4L    = 16'h1200;
   localparam logic [15:0] SCORE_SAT = 16'h9999;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD    = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Out-of-range line counts score nothing but are still consumed.
   function automatic logic [15:0] points_for(input logic [2:0] lines);
      case (lines)
         3'd1:    points_for = PTS_1L;
         3'd2:    points_for = PTS_2L;
         3'd3:    points_for = PTS_3L;
         3'd4:    points_for = PTS_4L;
         default: points_for = 16'h0000;
      endcase
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with carry in/out.
module bcd_digit_add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [4:0] sum;

   // NOTE: every output is assigned on both branches so no latch is inferred.
   always_comb begin
      sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
      if (sum > 5'd9) begin
         s    = sum[3:0] + 4'd6;
         cout = 1'b1;
      end else begin
         s    = sum[3:0];
         cout = 1'b0;
      end
   end

endmodule

// File: rtl/score_bcd_accumulator.sv
// Digit-serial packed-BCD score accumulator fed by line-clear events.
// Optional best-score register enabled by defining SCORE_HIGH_EN.
module score_bcd_accumulator
   import tetris_score_pkg::*;
#(
   parameter int DIGITS = SCORE_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  game_clr,
   input  logic                  clear_valid,
   input  logic [2:0]            clear_count,
   output logic                  clear_ready,
   output logic                  busy,
   output logic [4*DIGITS-1:0]   score_out
`ifdef SCORE_HIGH_EN
   ,
   output logic [4*DIGITS-1:0]   high_score_out
`endif
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   state_t          state;
   logic [W-1:0]    pts_r;
   logic [W-1:0]    acc_r;
   logic [IW-1:0]   idx_r;
   logic            carry_r;
   logic            ready_r;

   logic [3:0]      dig_a;
   logic [3:0]      dig_b;
   logic [3:0]      dig_s;
   logic            dig_c;
   logic [W-1:0]    commit_val;

   assign dig_a = acc_r[{idx_r, 2'b00} +: 4];
   assign dig_b = pts_r[{idx_r, 2'b00} +: 4];

   bcd_digit_add u_digit_add (
      .a    (dig_a),
      .b    (dig_b),
      .cin  (carry_r),
      .s    (dig_s),
      .cout (dig_c)
   );

   // A carry out of the top digit means the score overflowed: pin at all nines.
   assign commit_val  = carry_r ? W'(SCORE_SAT) : acc_r;
   assign busy        = (state != IDLE);
   assign clear_ready = ready_r & ~game_clr;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         score_out <= '0;
         pts_r     <= '0;
         acc_r     <= '0;
         idx_r     <= '0;
         carry_r   <= 1'b0;
         ready_r   <= 1'b0;
      end else if (game_clr) begin
         state     <= IDLE;
         score_out <= '0;
         ready_r   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (clear_valid && ready_r) begin
                  pts_r   <= W'(points_for(clear_count));
                  acc_r   <= score_out;
                  idx_r   <= '0;
                  carry_r <= 1'b0;
                  ready_r <= 1'b0;
                  state   <= ADD;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            ADD: begin
               acc_r[{idx_r, 2'b00} +: 4] <= dig_s;
               carry_r <= dig_c;
               idx_r   <= idx_r + 1'b1;
               if (idx_r == LAST_IDX) state <= COMMIT;
            end
            COMMIT: begin
               score_out <= commit_val;
               ready_r   <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SCORE_HIGH_EN
   // Packed BCD orders the same as binary, so a plain compare finds the best score.
   always_ff @(posedge clk) begin
      if (rst) begin
         high_score_out <= '0;
      end else if (!game_clr && state == COMMIT && commit_val > high_score_out) begin
         high_score_out <= commit_val;
      end
   end
`endif

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Self-checking bench for score_bcd_accumulator: directed table, abort/reset
// corner cases and random events against a decimal reference model.
module tb_score_bcd_accumulator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        game_clr = 1'b0;
   logic        clear_valid = 1'b0;
   logic [2:0]  clear_count = 3'd0;
   logic        clear_ready;
   logic        busy;
   logic [15:0] score_out;
`ifdef SCORE_HIGH_EN
   logic [15:0] high_score_out;
`endif

   int checks = 0;
   int failures = 0;
   int model_score = 0;
   int model_hi = 0;

   always #5 clk = ~clk;

   score_bcd_accumulator #(.DIGITS(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .game_clr       (game_clr),
      .clear_valid    (clear_valid),
      .clear_count    (clear_count),
      .clear_ready    (clear_ready),
      .busy           (busy),
      .score_out      (score_out)
`ifdef SCORE_HIGH_EN
      ,
      .high_score_out (high_score_out)
`endif
   );

   typedef struct {
      bit          clr;
      logic [2:0]  cnt;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r = '0;
      int t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int pts_dec(input logic [2:0] c);
      case (c)
         3'd1:    return 40;
         3'd2:    return 100;
         3'd3:    return 300;
         3'd4:    return 1200;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_event(input logic [2:0] cnt, input string tag);
      int n = 0;
      logic [15:0] prev;
      @(negedge clk);
      while (!clear_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " ready_before_accept"}, {15'b0, clear_ready}, 16'h1);
      if (!clear_ready) return;
      prev        = score_out;
      clear_valid = 1'b1;
      clear_count = cnt;
      model_score = (model_score + pts_dec(cnt) > 9999) ? 9999 : model_score + pts_dec(cnt);
      if (model_score > model_hi) model_hi = model_score;
      @(posedge clk);                    // edge T
      #1;
      clear_valid = 1'b0;
      clear_count = 3'($urandom);        // must be ignored after accept
      check({tag, " busy_after_accept"}, {15'b0, busy}, 16'h1);
      check({tag, " ready_after_accept"}, {15'b0, clear_ready}, 16'h0);
      repeat (4) @(posedge clk);         // edge T+4
      #1;
      check({tag, " score_held_T4"}, score_out, prev);
      @(posedge clk);                    // edge T+5
      #1;
      check({tag, " score_T5"}, score_out, to_bcd(model_score));
      check({tag, " idle_T5"}, {14'b0, busy, clear_ready}, 16'h0001);
`ifdef SCORE_HIGH_EN
      check({tag, " high_score"}, high_score_out, to_bcd(model_hi));
`endif
   endtask

   task automatic game_clear();
      @(negedge clk);
      game_clr = 1'b1;
      #1;
      check("game_clr ready_forced_low", {15'b0, clear_ready}, 16'h0);
      @(posedge clk);
      #1;
      game_clr    = 1'b0;
      model_score = 0;
      check("game_clr score_zero", score_out, 16'h0000);
      check("game_clr not_busy", {15'b0, busy}, 16'h0);
   endtask

   initial begin
      // Directed table: basic points, ignored counts, carry chain, saturation.
      vecs.push_back('{0, 3'd1, 16'h0040});
      vecs.push_back('{0, 3'd4, 16'h1240});
      vecs.push_back('{0, 3'd2, 16'h1340});
      vecs.push_back('{0, 3'd0, 16'h1340});
      vecs.push_back('{0, 3'd5, 16'h1340});
      vecs.push_back('{0, 3'd7, 16'h1340});
      vecs.push_back('{1, 3'd0, 16'h0000});
      vecs.push_back('{0, 3'd1, 16'h0040});
      vecs.push_back('{0, 3'd1, 16'h0080});
      vecs.push_back('{0, 3'd1, 16'h0120});
      vecs.push_back('{0, 3'd1, 16'h0160});
      vecs.push_back('{0, 3'd3, 16'h0460});
      vecs.push_back('{0, 3'd3, 16'h0760});
      vecs.push_back('{0, 3'd2, 16'h0860});
      vecs.push_back('{0, 3'd2, 16'h0960});
      vecs.push_back('{0, 3'd1, 16'h1000});
      vecs.push_back('{1, 3'd0, 16'h0000});
      for (int i = 0; i < 7; i++) vecs.push_back('{0, 3'd4, to_bcd(1200 * (i + 1))});
      vecs.push_back('{0, 3'd3, 16'h8700});
      vecs.push_back('{0, 3'd3, 16'h9000});
      vecs.push_back('{0, 3'd3, 16'h9300});
      vecs.push_back('{0, 3'd2, 16'h9400});
      vecs.push_back('{0, 3'd1, 16'h9440});
      vecs.push_back('{0, 3'd1, 16'h9480});
      vecs.push_back('{0, 3'd4, 16'h9999});
      vecs.push_back('{0, 3'd1, 16'h9999});

      // Reset for two cycles.
      repeat (2) @(posedge clk);
      #1;
      check("reset ready_low", {15'b0, clear_ready}, 16'h0);
      check("reset busy", {15'b0, busy}, 16'h0);
      check("reset score", score_out, 16'h0000);
`ifdef SCORE_HIGH_EN
      check("reset high_score", high_score_out, 16'h0000);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset ready", {15'b0, clear_ready}, 16'h1);
      check("post_reset score", score_out, 16'h0000);

      foreach (vecs[i]) begin
         if (vecs[i].clr) game_clear();
         else send_event(vecs[i].cnt, $sformatf("vec%0d", i));
         check($sformatf("vec%0d table_score", i), score_out, vecs[i].exp);
      end

      // game_clr two edges into an add, with a new event offered the same cycle.
      @(negedge clk);
      clear_valid = 1'b1;
      clear_count = 3'd4;
      @(posedge clk);                    // T: accepted
      #1;
      clear_valid = 1'b0;
      @(posedge clk);                    // T+1
      @(negedge clk);
      game_clr    = 1'b1;
      clear_valid = 1'b1;
      clear_count = 3'd1;
      #1;
      check("abort ready_forced_low", {15'b0, clear_ready}, 16'h0);
      @(posedge clk);                    // T+2
      #1;
      game_clr    = 1'b0;
      clear_valid = 1'b0;
      model_score = 0;
      check("abort score_zero", score_out, 16'h0000);
      check("abort idle_not_accepted", {15'b0, busy}, 16'h0);
      repeat (6) @(posedge clk);
      #1;
      check("abort no_late_commit", score_out, 16'h0000);
      check("abort still_idle", {15'b0, busy}, 16'h0);

      // Reset in the middle of an add discards it.
      send_event(3'd2, "pre_reset");
      @(negedge clk);
      clear_valid = 1'b1;
      clear_count = 3'd3;
      @(posedge clk);
      #1;
      clear_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst         = 1'b0;
      model_score = 0;
      model_hi    = 0;
      check("midreset busy", {15'b0, busy}, 16'h0);
      check("midreset ready_low", {15'b0, clear_ready}, 16'h0);
      check("midreset score", score_out, 16'h0000);
      repeat (6) @(posedge clk);
      #1;
      check("midreset no_commit", score_out, 16'h0000);
      check("midreset ready_back", {15'b0, clear_ready}, 16'h1);

      // Best score survives a new game.
      send_event(3'd3, "hs_a");
      send_event(3'd1, "hs_b");
      check("hs score_0340", score_out, 16'h0340);
      game_clear();
      send_event(3'd1, "hs_c");
      check("hs score_0040", score_out, 16'h0040);
`ifdef SCORE_HIGH_EN
      check("hs high_kept", high_score_out, 16'h0340);
`endif

      // Random events, gaps and new-game clears against the decimal model.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if ($urandom_range(0, 9) == 0) game_clear();
         else send_event(3'($urandom_range(0, 7)), $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/score_bcd_accumulator.md
# score_bcd_accumulator

Upstream score stage of the Tetris display path. Accepts line-clear events from the game logic, converts the cleared-line count to a BCD point value, and adds it to a 4-digit BCD running score with a digit-serial adder. Drives the 16-bit packed-BCD `score_out` consumed by the VGA score renderer, which reads it as four nibbles, MSD in [15:12].

## Interface
Parameters:
- `DIGITS`, 4: BCD digits in the score; fixed at 4 for the display; the width is `4*DIGITS`.

Ports:
- `clk`  in  1  system/pixel clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `game_clr`  in  1  synchronous clear of the current score at new-game start.
- `clear_valid`  in  1  line-clear event offered.
- `clear_count`  in  3  lines cleared in the event; valid values 1..4.
- `clear_ready`  out  1  block can accept an event.
- `busy`  out  1  an add is in progress.
- `score_out`  out  16  packed BCD score, digit 3 in [15:12].
- `high_score_out`  out  16  packed BCD best score; present only with `SCORE_HIGH_EN`.

## Operation
- Point table, packed BCD:
  - 1 line → 0x0040
  - 2 lines → 0x0100
  - 3 lines → 0x0300
  - 4 lines → 0x1200
  - 0, 5, 6 or 7 lines → 0x0000. The event is still accepted and committed, and the score is unchanged.
- FSM states: IDLE, ADD, COMMIT.
  - IDLE: `clear_ready`=1. When `clear_valid` && `clear_ready`:
    - latch the points into `pts_r`;
    - copy `score_out` into the work register `acc_r`;
    - set digit index to 0 and carry to 0;
    - go to ADD.
  - ADD: one digit per cycle, index 0 to 3.
    - Compute sum = acc digit + pts digit + carry, 5-bit.
    - If sum > 9: digit = sum + 6 (low 4 bits), carry = 1. Otherwise digit = sum, carry = 0.
    - After index 3, go to COMMIT.
  - COMMIT:
    - If the final carry is 1, the score saturates and `score_out` is set to 0x9999.
    - Otherwise `score_out` is set to `acc_r`.
    - Go to IDLE.
- `score_out` changes only in COMMIT, so the renderer never sees a partially added value.
- `game_clr` has priority over everything except `rst`:
  - `score_out` is set to 0;
  - any in-flight add is aborted and the FSM goes to IDLE;
  - an event offered in the same cycle is not accepted, because `clear_ready` is forced to 0 that cycle.
- Reset values: state IDLE, `score_out`=0, `high_score_out`=0, `clear_ready`=0 in the reset cycle and 1 afterwards, `busy`=0.
- `busy` = (state != IDLE).
- Reset mid-add: the add is discarded and nothing is committed.

## Timing
- Accept at edge T. ADD runs at edges T+1 to T+4. COMMIT at edge T+5.
- The new `score_out` is visible after edge T+5, which is 5 cycles of latency.
- `clear_ready` is low from T+1 through T+5 and high again after T+5.
- Throughput: one event per 6 cycles. Back-to-back events must be held by the producer until `clear_ready`=1.
- `clear_valid` must stay asserted until accepted.
- `clear_count` is sampled only in the accept cycle.

## Configuration
- `SCORE_HIGH_EN` defined:
  - `high_score_out` exists.
  - In COMMIT, if the committed score is greater than `high_score_out`, `high_score_out` takes the committed score.
  - `high_score_out` is cleared only by `rst`, never by `game_clr`.
- `SCORE_HIGH_EN` not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `tetris_score_pkg` holds:
  - the `DIGITS` default;
  - the BCD point constants `PTS_1L` to `PTS_4L`;
  - the saturation constant 0x9999;
  - the FSM state encoding.
- One sub-module, `bcd_digit_add`: a combinational single-digit BCD adder with inputs a[3:0], b[3:0], cin and outputs s[3:0], cout. It is instanced once and reused serially by the ADD state.

## Test plan
- `rst` for 2 cycles, then idle → `score_out`=0x0000, `clear_ready`=1, `busy`=0.
- From 0, event count=1 → 5 cycles later `score_out`=0x0040. Then count=4 → 0x1240. Then count=2 → 0x1340.
- Carry chain: preload score 0x0960 via events, then add count=1 → 0x1000, which checks the digit-1 to digit-2 carry.
- Saturation: build score 0x9480, then add count=4 → 0x9999. A further add of count=1 keeps 0x9999.
- `game_clr` asserted at T+2 of an add with `clear_valid` also high → `score_out`=0, FSM in IDLE, no commit, offered event not accepted that cycle.
- With `SCORE_HIGH_EN`: reach 0x0340, apply `game_clr`, then add count=1 → `score_out`=0x0040 and `high_score_out` stays 0x0340.
